// File: rtl/atm_msg_pkg.sv
// Shared types and constants for the ATM message sequencer.
// Optional abort support is enabled with ATM_MSG_ABORT_EN.
package atm_msg_pkg;

    localparam int MSG_W       = 8;
    localparam int NUM_ENTRIES = 16;
    localparam int SEL_W       = 4;
    localparam int LEN_W       = 5;
    localparam int MAX_LEN     = NUM_ENTRIES;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        SEND   = 2'd2,
        FINISH = 2'd3
    } state_t;

    function automatic logic [LEN_W-1:0] clamp_len(
        input logic [LEN_W-1:0] len
    );
        if (len > LEN_W'(MAX_LEN)) return LEN_W'(MAX_LEN);
        return len;
    endfunction

endpackage

// File: rtl/atm_msg_index_counter.sv
// Message index counter: clear, increment and last-entry compare.
// Used by atm_msg_sequencer (ATM_MSG_ABORT_EN does not affect it).
module atm_msg_index_counter
    import atm_msg_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic [LEN_W-1:0] i_len,
    output logic [SEL_W-1:0] o_idx,
    output logic             o_last
);

    logic [SEL_W-1:0] r_idx;
    logic [LEN_W-1:0] w_last_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (i_clr) begin
            r_idx <= '0;
        end else if (i_inc) begin
            r_idx <= r_idx + SEL_W'(1);
        end
    end

    // Compare in LEN_W bits so a 16-byte message ends at index 15.
    assign w_last_idx = i_len - LEN_W'(1);
    assign o_last     = ({1'b0, r_idx} == w_last_idx);
    assign o_idx      = r_idx;

endmodule

// File: rtl/atm_msg_sequencer.sv
// Steps the 16:1 message mux and streams bytes over valid/ready.
// Define ATM_MSG_ABORT_EN to add the Abort input.
module atm_msg_sequencer
    import atm_msg_pkg::*;
#(
    parameter int DATA_W = MSG_W
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic [LEN_W-1:0]  Len,
    output logic [SEL_W-1:0]  S,
    input  logic [DATA_W-1:0] MuxF,
    output logic [DATA_W-1:0] Data,
    output logic              Valid,
    input  logic              Ready,
    output logic              Busy,
    output logic              Done
`ifdef ATM_MSG_ABORT_EN
    ,
    input  logic              Abort
`endif
);

    state_t           r_state;
    logic [LEN_W-1:0] r_len;
    logic [DATA_W-1:0] r_data;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;

    logic             w_abort;
    logic             w_start;
    logic             w_accept;
    logic             w_clr;
    logic             w_inc;
    logic             w_last;
    logic [SEL_W-1:0] w_idx;

`ifdef ATM_MSG_ABORT_EN
    assign w_abort = Abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_start  = Start & ~w_abort;
    assign w_accept = (r_state == SEND) & r_valid & Ready;
    assign w_clr    = (r_state == IDLE) & w_start & (Len != '0);
    // Abort wins over a same-cycle handshake: the byte is not counted.
    assign w_inc    = w_accept & ~w_last & ~w_abort;

    atm_msg_index_counter u_idx (
        .clk    (Clock),
        .rst_n  (Resetn),
        .i_clr  (w_clr),
        .i_inc  (w_inc),
        .i_len  (r_len),
        .o_idx  (w_idx),
        .o_last (w_last)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= IDLE;
            r_len   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (w_abort && (r_state != IDLE)) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_busy <= 1'b1;
                        if (Len == '0) begin
                            r_state <= FINISH;
                            r_done  <= 1'b1;
                        end else begin
                            r_len   <= clamp_len(Len);
                            r_state <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    r_data  <= MuxF;
                    r_valid <= 1'b1;
                    r_state <= SEND;
                end
                SEND: begin
                    if (w_accept) begin
                        r_valid <= 1'b0;
                        if (w_last) begin
                            r_state <= FINISH;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= FETCH;
                        end
                    end
                end
                FINISH: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign S     = w_idx;
    assign Data  = r_data;
    assign Valid = r_valid;
    assign Busy  = r_busy;
    assign Done  = r_done;

endmodule

// File: tb/tb_atm_msg_sequencer.sv
// Directed bench for atm_msg_sequencer with a modelled 16:1 mux.
// Abort scenarios run when ATM_MSG_ABORT_EN is defined.
module tb_atm_msg_sequencer;

    logic       Clock  = 1'b0;
    logic       Resetn = 1'b0;
    logic       Start  = 1'b0;
    logic       Ready  = 1'b0;
    logic [4:0] Len    = 5'd0;
    logic [3:0] S;
    logic [7:0] MuxF;
    logic [7:0] Data;
    logic       Valid;
    logic       Busy;
    logic       Done;
`ifdef ATM_MSG_ABORT_EN
    logic       Abort  = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       start;
        logic [4:0] len;
        logic       ready;
        logic [3:0] s;
        logic [7:0] data;
        logic       valid;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl[$];

    always #5 Clock = ~Clock;

    // Mux entries W0..W15 hold 8'h41..8'h50
    assign MuxF = 8'h41 + {4'h0, S};

    atm_msg_sequencer dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Start  (Start),
        .Len    (Len),
        .S      (S),
        .MuxF   (MuxF),
        .Data   (Data),
        .Valid  (Valid),
        .Ready  (Ready),
        .Busy   (Busy),
        .Done   (Done)
`ifdef ATM_MSG_ABORT_EN
        ,
        .Abort  (Abort)
`endif
    );

    function automatic vec_t mk(
        input logic st, input logic [4:0] ln, input logic rd,
        input logic [3:0] s, input logic [7:0] d,
        input logic v, input logic b, input logic dn
    );
        vec_t t;
        t.start = st; t.len = ln; t.ready = rd;
        t.s = s; t.data = d; t.valid = v; t.busy = b; t.done = dn;
        return t;
    endfunction

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic run_msg(input logic [4:0] len_in, input int nbytes,
                           input int stall_idx, input int stall_n,
                           input bit hammer);
        Start = 1'b1;
        Len   = len_in;
        Ready = 1'b1;
        step();
        if (hammer) Len = 5'd7;
        else        Start = 1'b0;
        for (int i = 0; i < nbytes; i++) begin
            chk($sformatf("fetch%0d_s", i), S, i);
            chk($sformatf("fetch%0d_v", i), Valid, 0);
            chk($sformatf("fetch%0d_b", i), Busy, 1);
            chk($sformatf("fetch%0d_d", i), Done, 0);
            step();
            chk($sformatf("send%0d_s", i), S, i);
            chk($sformatf("send%0d_data", i), Data, 8'h41 + i);
            chk($sformatf("send%0d_v", i), Valid, 1);
            if (i == stall_idx) begin
                Ready = 1'b0;
                for (int j = 0; j < stall_n; j++) begin
                    step();
                    chk($sformatf("stall%0d_v", j), Valid, 1);
                    chk($sformatf("stall%0d_data", j), Data, 8'h41 + i);
                    chk($sformatf("stall%0d_s", j), S, i);
                end
                Ready = 1'b1;
            end
            step();
        end
        chk("finish_done", Done, 1);
        chk("finish_busy", Busy, 1);
        chk("finish_v", Valid, 0);
        step();
        Start = 1'b0;
        chk("idle_done", Done, 0);
        chk("idle_busy", Busy, 0);
        chk("idle_s_hold", S, nbytes - 1);
    endtask

    initial begin
        int ndone;

        tbl.push_back(mk(0, 0, 1, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, 5, 1, 0, 8'h00, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 8'h41, 1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 8'h41, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 8'h42, 1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 2, 8'h42, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 2, 8'h43, 1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 3, 8'h43, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 3, 8'h44, 1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 4, 8'h44, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 4, 8'h45, 1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 4, 8'h45, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 4, 8'h45, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 4, 8'h45, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 4, 8'h45, 0, 0, 0));

        #12;
        chk("rst_s", S, 0);
        chk("rst_data", Data, 0);
        chk("rst_v", Valid, 0);
        chk("rst_b", Busy, 0);
        chk("rst_d", Done, 0);
        Resetn = 1'b1;
        step();

        foreach (tbl[i]) begin
            Start = tbl[i].start;
            Len   = tbl[i].len;
            Ready = tbl[i].ready;
            step();
            chk($sformatf("vec%0d_s", i), S, tbl[i].s);
            chk($sformatf("vec%0d_data", i), Data, tbl[i].data);
            chk($sformatf("vec%0d_v", i), Valid, tbl[i].valid);
            chk($sformatf("vec%0d_b", i), Busy, tbl[i].busy);
            chk($sformatf("vec%0d_d", i), Done, tbl[i].done);
        end
        Start = 1'b0;

        run_msg(5'd5, 5, 2, 3, 1'b0);
        run_msg(5'd20, 16, -1, 0, 1'b0);
        run_msg(5'd3, 3, -1, 0, 1'b1);

        Start = 1'b1;
        Len   = 5'd5;
        Ready = 1'b1;
        step();
        Start = 1'b0;
        repeat (5) step();
        chk("pre_rst_v", Valid, 1);
        chk("pre_rst_data", Data, 8'h43);
        #2;
        Resetn = 1'b0;
        #1;
        chk("arst_s", S, 0);
        chk("arst_data", Data, 0);
        chk("arst_v", Valid, 0);
        chk("arst_b", Busy, 0);
        chk("arst_d", Done, 0);
        step();
        Resetn = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (Done || Busy) ndone++;
        end
        chk("post_rst_quiet", ndone, 0);
        run_msg(5'd2, 2, -1, 0, 1'b0);

`ifdef ATM_MSG_ABORT_EN
        Start = 1'b1;
        Len   = 5'd5;
        Ready = 1'b1;
        step();
        Start = 1'b0;
        repeat (7) step();
        chk("ab_pre_s", S, 3);
        chk("ab_pre_v", Valid, 1);
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        chk("ab_v", Valid, 0);
        chk("ab_b", Busy, 0);
        chk("ab_d", Done, 0);
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (Done || Busy) ndone++;
        end
        chk("ab_quiet", ndone, 0);
        Abort = 1'b1;
        Start = 1'b1;
        Len   = 5'd4;
        step();
        Abort = 1'b0;
        Start = 1'b0;
        chk("ab_idle_start", Busy, 0);
        run_msg(5'd5, 5, -1, 0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
